// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Registered RV32 instruction-decode stage. Decodes OP-IMM, OP, LUI and AUIPC,
// reads the register file, forwards operands from EX/MEM, stalls on load-use
// hazards and holds a valid/ready ID/EX output register with flush support.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_pc, in_inst           instruction PC and word
//   rf_raddr1/2, rf_rdata1/2 register-file read port (same-cycle data)
//   ex_we/ex_is_load/ex_waddr/ex_wdata   EX-stage writeback info
//   mem_we/mem_waddr/mem_wdata           MEM-stage writeback info
//   flush                    kill held and incoming instruction
//   out_valid/out_ready      downstream handshake
//   out_pc, out_aluop, out_alusel, out_op1, out_op2,
//   out_we, out_waddr, out_illegal       decoded ID/EX register contents
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_inst,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [RA_W-1:0]   ex_waddr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              mem_we,
    input  logic [RA_W-1:0]   mem_waddr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [3:0]        out_aluop,
    output logic [2:0]        out_alusel,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic              out_we,
    output logic [RA_W-1:0]   out_waddr,
    output logic              out_illegal
);

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'd0,
        SEL_ALU   = 3'd1,
        SEL_LUI   = 3'd2,
        SEL_AUIPC = 3'd3
    } alusel_e;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [RA_W-1:0] w_rd;
    logic [RA_W-1:0] w_rs1;
    logic [RA_W-1:0] w_rs2;

    assign w_opcode  = in_inst[6:0];
    assign w_funct3  = in_inst[14:12];
    assign w_rd      = RA_W'(in_inst[11:7]);
    assign w_rs1     = RA_W'(in_inst[19:15]);
    assign w_rs2     = RA_W'(in_inst[24:20]);
    assign rf_raddr1 = w_rs1;
    assign rf_raddr2 = w_rs2;

    // Operand source selection: x0 reads zero, EX beats MEM, MEM beats the RF.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_hit_we,
        input logic [RA_W-1:0] ex_addr,
        input logic [XLEN-1:0] ex_val,
        input logic            mem_hit_we,
        input logic [RA_W-1:0] mem_addr,
        input logic [XLEN-1:0] mem_val
    );
        if (addr == '0)
            return '0;
        if (FWD_EN != 0 && ex_hit_we && ex_addr == addr)
            return ex_val;
        if (FWD_EN != 0 && mem_hit_we && mem_addr == addr)
            return mem_val;
        return rf_val;
    endfunction

    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;

    assign w_src1 = resolve(w_rs1, rf_rdata1, ex_we, ex_waddr, ex_wdata,
                            mem_we, mem_waddr, mem_wdata);
    assign w_src2 = resolve(w_rs2, rf_rdata2, ex_we, ex_waddr, ex_wdata,
                            mem_we, mem_waddr, mem_wdata);

    // Decoded next values for the ID/EX register
    logic [3:0]      w_aluop;
    alusel_e         w_alusel;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_we;
    logic            w_illegal;
    logic            w_use1;
    logic            w_use2;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path through the case can infer a latch.
        w_aluop   = '0;
        w_alusel  = SEL_NOP;
        w_op1     = '0;
        w_op2     = '0;
        w_we      = 1'b0;
        w_illegal = 1'b0;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_alusel = SEL_ALU;
                w_use1   = 1'b1;
                w_op1    = w_src1;
                // Shifts take the 5-bit shamt; inst[30] then selects SRAI vs SRLI.
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    w_op2 = XLEN'(in_inst[24:20]);
                else
                    w_op2 = XLEN'($signed(in_inst[31:20]));
                w_aluop = {(w_funct3 == 3'b101) && in_inst[30], w_funct3};
                w_we    = (w_rd != '0);
            end
            OPC_OP: begin
                w_alusel = SEL_ALU;
                w_use1   = 1'b1;
                w_use2   = 1'b1;
                w_op1    = w_src1;
                w_op2    = w_src2;
                w_aluop  = {in_inst[30], w_funct3};
                w_we     = (w_rd != '0);
            end
            OPC_LUI: begin
                w_alusel = SEL_LUI;
                w_op2    = XLEN'($signed({in_inst[31:12], 12'b0}));
                w_we     = (w_rd != '0);
            end
            OPC_AUIPC: begin
                w_alusel = SEL_AUIPC;
                w_op1    = in_pc;
                w_op2    = XLEN'($signed({in_inst[31:12], 12'b0}));
                w_we     = (w_rd != '0);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Load-use hazard: the loaded value is not available yet, so forwarding
    // from EX would hand over the address, not the data.
    logic w_stall;
    logic w_advance;
    logic w_accept;

    assign w_stall = in_valid && ex_is_load && ex_we && (ex_waddr != '0) &&
                     ((w_use1 && w_rs1 == ex_waddr) || (w_use2 && w_rs2 == ex_waddr));
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance && !w_stall && !flush && !rst;
    assign w_accept  = in_valid && in_ready;

    // ID/EX register
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [3:0]      r_aluop;
    logic [2:0]      r_alusel;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic            r_we;
    logic [RA_W-1:0] r_waddr;
    logic            r_illegal;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_aluop   <= '0;
            r_alusel  <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= in_pc;
                r_aluop   <= w_aluop;
                r_alusel  <= w_alusel;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
                r_we      <= w_we;
                r_waddr   <= w_rd;
                r_illegal <= w_illegal;
            end else begin
                // Bubble: nothing to issue (idle upstream or load-use stall).
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_aluop   = r_aluop;
    assign out_alusel  = r_alusel;
    assign out_op1     = r_op1;
    assign out_op2     = r_op2;
    assign out_we      = r_we;
    assign out_waddr   = r_waddr;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Self-checking bench for id_stage_pipe: directed vector table, hand-written
// multi-cycle sequences (reset, load-use, backpressure/flush, mid-op reset)
// and randomized traffic against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        ex_we;
        logic        ex_load;
        logic [4:0]  ex_waddr;
        logic [31:0] ex_wdata;
        logic        mem_we;
        logic [4:0]  mem_waddr;
        logic [31:0] mem_wdata;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        we;
        logic [4:0]  waddr;
        logic        illegal;
    } exp_t;

    typedef struct {
        stim_t       s;
        exp_t        e;
        logic [31:0] nf_op1;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [31:0]     in_pc;
    logic [31:0]     in_inst;
    logic [31:0]     rf_rdata1, rf_rdata2;
    logic            ex_we, ex_is_load;
    logic [4:0]      ex_waddr;
    logic [31:0]     ex_wdata;
    logic            mem_we;
    logic [4:0]      mem_waddr;
    logic [31:0]     mem_wdata;
    logic            flush;
    logic            out_ready;

    logic            in_ready;
    logic [4:0]      rf_raddr1, rf_raddr2;
    logic            out_valid;
    logic [31:0]     out_pc;
    logic [3:0]      out_aluop;
    logic [2:0]      out_alusel;
    logic [31:0]     out_op1, out_op2;
    logic            out_we;
    logic [4:0]      out_waddr;
    logic            out_illegal;

    logic            nf_in_ready;
    logic [4:0]      nf_raddr1, nf_raddr2;
    logic            nf_valid;
    logic [31:0]     nf_pc;
    logic [3:0]      nf_aluop;
    logic [2:0]      nf_alusel;
    logic [31:0]     nf_op1, nf_op2;
    logic            nf_we;
    logic [4:0]      nf_waddr;
    logic            nf_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_aluop(out_aluop), .out_alusel(out_alusel),
        .out_op1(out_op1), .out_op2(out_op2), .out_we(out_we),
        .out_waddr(out_waddr), .out_illegal(out_illegal)
    );

    id_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(nf_raddr1), .rf_raddr2(nf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flush(flush), .out_valid(nf_valid), .out_ready(out_ready),
        .out_pc(nf_pc), .out_aluop(nf_aluop), .out_alusel(nf_alusel),
        .out_op1(nf_op1), .out_op2(nf_op2), .out_we(nf_we),
        .out_waddr(nf_waddr), .out_illegal(nf_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e, input bit full);
        check({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
        if (full) begin
            check({tag, ".aluop"},   32'(out_aluop),   32'(e.aluop));
            check({tag, ".alusel"},  32'(out_alusel),  32'(e.alusel));
            check({tag, ".op1"},     out_op1,          e.op1);
            check({tag, ".op2"},     out_op2,          e.op2);
            check({tag, ".we"},      32'(out_we),      32'(e.we));
            check({tag, ".waddr"},   32'(out_waddr),   32'(e.waddr));
            check({tag, ".illegal"}, 32'(out_illegal), 32'(e.illegal));
        end
    endtask

    task automatic apply(input stim_t s);
        in_pc     = s.pc;
        in_inst   = s.inst;
        rf_rdata1 = s.rf1;
        rf_rdata2 = s.rf2;
        ex_we     = s.ex_we;
        ex_is_load = s.ex_load;
        ex_waddr  = s.ex_waddr;
        ex_wdata  = s.ex_wdata;
        mem_we    = s.mem_we;
        mem_waddr = s.mem_waddr;
        mem_wdata = s.mem_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_src(input logic [4:0] a, input logic [31:0] rf, input stim_t s);
        if (a == 5'd0) return 32'd0;
        if (s.ex_we && s.ex_waddr == a) return s.ex_wdata;
        if (s.mem_we && s.mem_waddr == a) return s.mem_wdata;
        return rf;
    endfunction

    function automatic exp_t model_decode(input stim_t s);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        opc = s.inst[6:0];
        f3  = s.inst[14:12];
        rd  = s.inst[11:7];
        e = '0;
        e.valid = 1'b1;
        e.waddr = rd;
        case (opc)
            7'h13: begin
                e.alusel = 3'd1;
                e.op1    = model_src(s.inst[19:15], s.rf1, s);
                if (f3 == 3'd1 || f3 == 3'd5) e.op2 = 32'(s.inst[24:20]);
                else e.op2 = 32'($signed(s.inst) >>> 20);
                e.aluop = {(f3 == 3'd5) && s.inst[30], f3};
                e.we    = (rd != 5'd0);
            end
            7'h33: begin
                e.alusel = 3'd1;
                e.op1    = model_src(s.inst[19:15], s.rf1, s);
                e.op2    = model_src(s.inst[24:20], s.rf2, s);
                e.aluop  = {s.inst[30], f3};
                e.we     = (rd != 5'd0);
            end
            7'h37: begin
                e.alusel = 3'd2;
                e.op2    = s.inst & 32'hFFFF_F000;
                e.we     = (rd != 5'd0);
            end
            7'h17: begin
                e.alusel = 3'd3;
                e.op1    = s.pc;
                e.op2    = s.inst & 32'hFFFF_F000;
                e.we     = (rd != 5'd0);
            end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit model_stall(input stim_t s, input bit valid);
        bit uses1, uses2;
        uses1 = (s.inst[6:0] == 7'h13) || (s.inst[6:0] == 7'h33);
        uses2 = (s.inst[6:0] == 7'h33);
        return valid && s.ex_load && s.ex_we && (s.ex_waddr != 5'd0) &&
               ((uses1 && s.inst[19:15] == s.ex_waddr) || (uses2 && s.inst[24:20] == s.ex_waddr));
    endfunction

    // ---------------- test ----------------
    vec_t vecs[10];
    exp_t zero_e;
    exp_t m;
    stim_t rs;

    initial begin
        zero_e = '0;

        //        pc            inst          rf1           rf2           exwe exld exwa   exwd          mwe  mwa    mwd
        vecs[0] = '{'{32'h3C, 32'h0050_0093, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h0, 3'd1, 32'h0, 32'h5, 1'b1, 5'd1, 1'b0}, 32'h0};
        vecs[1] = '{'{32'h40, 32'h1234_5237, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h0, 3'd2, 32'h0, 32'h1234_5000, 1'b1, 5'd4, 1'b0}, 32'h0};
        vecs[2] = '{'{32'h44, 32'h0021_01B3, 32'hAAAA, 32'hAAAA, 1'b1, 1'b0, 5'd2, 32'h1234, 1'b1, 5'd2, 32'h1111},
                    '{1'b1, 4'h0, 3'd1, 32'h1234, 32'h1234, 1'b1, 5'd3, 1'b0}, 32'hAAAA};
        vecs[3] = '{'{32'h48, 32'h0021_01B3, 32'hAAAA, 32'hAAAA, 1'b0, 1'b0, 5'd2, 32'h1234, 1'b1, 5'd2, 32'h1111},
                    '{1'b1, 4'h0, 3'd1, 32'h1111, 32'h1111, 1'b1, 5'd3, 1'b0}, 32'hAAAA};
        vecs[4] = '{'{32'h4C, 32'h0000_007F, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1}, 32'h0};
        vecs[5] = '{'{32'h100, 32'hFFFF_F397, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h0, 3'd3, 32'h100, 32'hFFFF_F000, 1'b1, 5'd7, 1'b0}, 32'h100};
        vecs[6] = '{'{32'h104, 32'h40A4_8433, 32'h55, 32'h66, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h8, 3'd1, 32'h55, 32'h66, 1'b1, 5'd8, 1'b0}, 32'h55};
        vecs[7] = '{'{32'h108, 32'hFFF0_8013, 32'h77, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h0, 3'd1, 32'h77, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0}, 32'h77};
        vecs[8] = '{'{32'h10C, 32'h01F1_9113, 32'h9, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h1, 3'd1, 32'h9, 32'd31, 1'b1, 5'd2, 1'b0}, 32'h9};
        // OP-IMM whose imm field aliases the EX load destination must not stall.
        vecs[9] = '{'{32'h110, 32'h0051_0093, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0},
                    '{1'b1, 4'h0, 3'd1, 32'h10, 32'h5, 1'b1, 5'd1, 1'b0}, 32'h10};

        // Reset held two cycles with a valid instruction presented
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        apply(vecs[0].s);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("rst.in_ready", 32'(in_ready), 32'h0);
            tick();
            check_outs("rst", zero_e, 1'b1);
            check("rst.pc", out_pc, 32'h0);
        end
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].s);
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'h1);
            check($sformatf("vec%0d.raddr1", i), 32'(rf_raddr1), 32'(vecs[i].s.inst[19:15]));
            check($sformatf("vec%0d.raddr2", i), 32'(rf_raddr2), 32'(vecs[i].s.inst[24:20]));
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e, 1'b1);
            check($sformatf("vec%0d.pc", i), out_pc, vecs[i].s.pc);
            check($sformatf("vec%0d.nofwd_op1", i), nf_op1, vecs[i].nf_op1);
        end

        // Backpressure: held instruction stays stable, nothing accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        apply(vecs[6].s);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.in_ready", 32'(in_ready), 32'h0);
            tick();
            check_outs($sformatf("bp%0d", c), vecs[9].e, 1'b1);
            check("bp.pc", out_pc, vecs[9].s.pc);
        end
        // Flush overrides backpressure and drops the presented instruction
        flush = 1'b1;
        #1;
        check("flush.in_ready", 32'(in_ready), 32'h0);
        tick();
        check("flush.valid", 32'(out_valid), 32'h0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("post_flush.valid", 32'(out_valid), 32'h0);

        // Load-use stall on SRAI x5,x6,3 behind a load to x6
        apply('{32'h200, 32'h4033_5293, 32'h0, 32'h0, 1'b1, 1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'h0});
        in_valid = 1'b1;
        #1;
        check("lu.in_ready", 32'(in_ready), 32'h0);
        tick();
        check("lu.bubble", 32'(out_valid), 32'h0);
        ex_is_load = 1'b0;
        #1;
        check("lu2.in_ready", 32'(in_ready), 32'h1);
        tick();
        check_outs("lu2", '{1'b1, 4'hD, 3'd1, 32'h600, 32'h3, 1'b1, 5'd5, 1'b0}, 1'b1);

        // Mid-operation reset clears a held instruction
        apply(vecs[1].s);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("midrst", zero_e, 1'b1);
        check("midrst.pc", out_pc, 32'h0);

        // Randomized traffic against the model (starts from a clean reset)
        m = '0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            logic [6:0]  opc;
            bit          exp_ready;
            case ($urandom_range(0, 4))
                0: opc = 7'h13;
                1: opc = 7'h33;
                2: opc = 7'h37;
                3: opc = 7'h17;
                default: opc = 7'h03;
            endcase
            r = $urandom;
            rs.inst      = {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            r[14:12], 5'($urandom_range(0, 3)), opc};
            rs.pc        = $urandom & 32'hFFFF_FFFC;
            rs.rf1       = $urandom;
            rs.rf2       = $urandom;
            rs.ex_we     = 1'($urandom_range(0, 1));
            rs.ex_load   = ($urandom_range(0, 2) == 0);
            rs.ex_waddr  = 5'($urandom_range(0, 3));
            rs.ex_wdata  = $urandom;
            rs.mem_we    = 1'($urandom_range(0, 1));
            rs.mem_waddr = 5'($urandom_range(0, 3));
            rs.mem_wdata = $urandom;
            apply(rs);
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            #1;
            exp_ready = !rst && (!m.valid || out_ready) && !model_stall(rs, in_valid) && !flush;
            check("rnd.in_ready", 32'(in_ready), 32'(exp_ready));
            tick();
            if (rst)
                m = '0;
            else if (flush)
                m.valid = 1'b0;
            else if (!m.valid || out_ready) begin
                if (in_valid && exp_ready) m = model_decode(rs);
                else m.valid = 1'b0;
            end
            check_outs($sformatf("rnd%0d", i), m, m.valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, registered RV32 instruction-decode stage for the in-order pipeline; sits between the IF/ID register and EX.
- Decodes OP-IMM, OP, LUI and AUIPC, reads the register file, and forwards operands from EX and MEM.
- Detects load-use hazards and stalls on them.
- Holds a valid/ready-handshaked ID/EX output register with flush support.

Parameters:
- XLEN, 32, datapath/register width.
- RA_W, 5, register address width.
- FWD_EN, 1, 1 enables EX/MEM forwarding; 0 always uses register-file data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept the upstream instruction.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  32  instruction word.
- rf_raddr1, rf_raddr2  out  RA_W  register-file read addresses, combinational = inst[19:15], inst[24:20].
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data, same cycle.
- ex_we, ex_is_load  in  1  EX-stage instruction writes a register / is a load.
- ex_waddr  in  RA_W  EX-stage destination register.
- ex_wdata  in  XLEN  EX-stage result.
- mem_we  in  1  MEM-stage instruction writes a register.
- mem_waddr  in  RA_W  MEM-stage destination register.
- mem_wdata  in  XLEN  MEM-stage result.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts the held instruction.
- out_pc  out  XLEN  PC of the held instruction.
- out_aluop  out  4  {alt, funct3}.
- out_alusel  out  3  0 NOP, 1 ALU, 2 LUI, 3 AUIPC.
- out_op1, out_op2  out  XLEN  resolved operands.
- out_we  out  1  writes rd.
- out_waddr  out  RA_W  destination register.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset: every out_* register is 0, including out_valid.
- Accept condition: in_valid && in_ready. Latency is 1 cycle, so decoded fields appear on out_* the cycle after acceptance.
- Output register advances when !out_valid || out_ready (the advance condition).
- in_ready = advance && !stall && !flush.
- Output holding: while out_valid && !out_ready, every out_* holds stable.

Decode:
- OP-IMM (0x13): alusel 1, op1 = rs1 value, op2 = sign-extended inst[31:20].
  - For funct3 001/101, op2 = zero-extended shamt inst[24:20] instead.
  - alt = inst[30] only for funct3 101, else 0.
- OP (0x33): alusel 1, op1 = rs1 value, op2 = rs2 value, alt = inst[30].
- LUI (0x37): alusel 2, op1 = 0, op2 = {inst[31:12], 12'b0}.
- AUIPC (0x17): alusel 3, op1 = pc, op2 = {inst[31:12], 12'b0}.
- we = (rd != 0) for all four classes. aluop = 0 for LUI/AUIPC.
- Any other opcode: out_valid 1, out_illegal 1, we 0, alusel 0, op1/op2 0.

Operand resolution, per source the instruction actually uses:
- Source address 0 gives 0.
- Else, with FWD_EN: ex_we && ex_waddr match gives ex_wdata; then mem_we && mem_waddr match gives mem_wdata.
- Otherwise rf_rdata. EX has priority over MEM.

Load-use stall:
- stall = in_valid && ex_is_load && ex_we && ex_waddr != 0 && a used source address == ex_waddr.
- rs2 counts as used only for OP.
- On stall with advance, the output register loads a bubble (out_valid 0).
- The input is not consumed; upstream holds in_pc/in_inst.
- Stall takes precedence over the EX forward.

Flush:
- Next edge forces out_valid 0, regardless of out_ready.
- The incoming instruction is dropped; in_ready is 0 that cycle.
- Flush overrides stall and backpressure. rst overrides flush.

Other boundary rules:
- in_valid 0 while advancing: out_valid goes 0.
- Mid-operation reset: all state is cleared next edge; no partial instruction survives.

Test Plan:
- Reset: hold rst 2 cycles with in_valid 1 -> out_valid 0 and all out_* 0 throughout; in_ready 0 during rst.
- ADDI x1,x0,5 (0x00500093), then LUI x4,0x12345 (0x12345237) at pc 0x40, out_ready 1 -> next cycle out_valid 1, aluop 0x0, alusel 1, op1 0, op2 5, we 1, waddr 1; following cycle alusel 2, op1 0, op2 0x12345000, waddr 4.
- Forwarding: ADD x3,x2,x2 (0x002101B3) with rf_rdata 0xAAAA, mem_we 1/mem_waddr 2/mem_wdata 0x1111, ex_we 1/ex_waddr 2/ex_wdata 0x1234 -> op1 = op2 = 0x1234; with ex_we 0 -> 0x1111; with FWD_EN=0 -> 0xAAAA.
- Load-use: ex_is_load 1, ex_we 1, ex_waddr 6, instruction SRAI x5,x6,3 (0x40335293) -> in_ready 0, out_valid 0 for that cycle; drop ex_is_load -> accepted, aluop 0xD, op2 3, waddr 5.
- Backpressure then flush: out_valid 1, out_ready 0 for 3 cycles -> out_* stable and in_ready 0; assert flush -> out_valid 0 next cycle, in_ready 0 during flush, the instruction presented is not issued.
- Illegal: in_inst 0x0000007F -> out_valid 1, out_illegal 1, out_we 0, alusel 0.
